// File: rtl/seq_gen_pkg.sv
// Shared types and constants for the 10110 pattern generator: state encoding,
// default pattern, and the self-overlap (OVL) computation.
package seq_gen_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        FIN  = 2'd2
    } state_t;

    localparam int                     DEF_PAT_W   = 5;
    localparam logic [DEF_PAT_W-1:0]   DEF_PATTERN = 5'b10110;

    // Longest proper prefix of the pattern (top bits) that is also a suffix.
    function automatic int calc_ovl(input logic [15:0] pat, input int w);
        int   best;
        logic match;
        best = 0;
        for (int k = 1; k < w; k++) begin
            match = 1'b1;
            for (int i = 0; i < k; i++) begin
                if (pat[4'(w - k + i)] != pat[4'(i)]) match = 1'b0;
            end
            if (match) best = k;
        end
        return best;
    endfunction

endpackage

// File: rtl/seq_gen_shifter.sv
// Loadable PAT_W-bit shift register with a down-counting bit index; supports a
// full pattern load and a suffix-only load for overlapped instances.
module seq_gen_shifter
    import seq_gen_pkg::*;
#(
    parameter int               PAT_W   = DEF_PAT_W,
    parameter logic [PAT_W-1:0] PATTERN = DEF_PATTERN,
    parameter int               OVL     = 0
) (
    input  logic clk,
    input  logic load_full,
    input  logic load_part,
    input  logic shift_en,
    output logic msb,
    output logic last_bit
);

    localparam int IDXW = (PAT_W > 1) ? $clog2(PAT_W) : 1;
    localparam logic [IDXW-1:0]  IDX_FULL = IDXW'(PAT_W - 1);
    localparam logic [IDXW-1:0]  IDX_PART = IDXW'(PAT_W - OVL - 1);
    // Suffix load is top-aligned so the MSB-first path stays the same.
    localparam logic [PAT_W-1:0] PAT_PART = PATTERN << OVL;

    logic [PAT_W-1:0] sr_q, sr_d;
    logic [IDXW-1:0]  idx_q, idx_d;

    always_comb begin
        sr_d  = sr_q;
        idx_d = idx_q;
        if (load_full) begin
            sr_d  = PATTERN;
            idx_d = IDX_FULL;
        end else if (load_part) begin
            sr_d  = PAT_PART;
            idx_d = IDX_PART;
        end else if (shift_en) begin
            sr_d  = {sr_q[PAT_W-2:0], 1'b0};
            idx_d = idx_q - IDXW'(1);
        end
    end

    always_ff @(posedge clk) begin
        sr_q  <= sr_d;
        idx_q <= idx_d;
    end

    assign msb      = sr_q[PAT_W-1];
    assign last_bit = (idx_q == '0);

endmodule

// File: rtl/seq_10110_gen.sv
// Serial pattern transmitter: emits PATTERN MSB-first for a requested number of
// instances, back-to-back or overlapped. Optional exp_det output: SEQ_GEN_EXPECT_EN.
module seq_10110_gen
    import seq_gen_pkg::*;
#(
    parameter int               PAT_W   = DEF_PAT_W,
    parameter logic [PAT_W-1:0] PATTERN = DEF_PATTERN,
    parameter int               CNT_W   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] count,
    input  logic             overlap,
    output logic             in_seq,
    output logic             seq_valid,
    output logic             busy,
    output logic             done
`ifdef SEQ_GEN_EXPECT_EN
    ,
    output logic             exp_det
`endif
);

    localparam int OVL = calc_ovl(16'(PATTERN), PAT_W);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovl_mode_q, ovl_mode_d;
    logic             done_q, done_d;
    logic             load_full, load_part, shift_en;
    logic             msb, last_bit;

    seq_gen_shifter #(
        .PAT_W   (PAT_W),
        .PATTERN (PATTERN),
        .OVL     (OVL)
    ) u_shifter (
        .clk       (clk),
        .load_full (load_full),
        .load_part (load_part),
        .shift_en  (shift_en),
        .msb       (msb),
        .last_bit  (last_bit)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        ovl_mode_d = ovl_mode_q;
        done_d     = 1'b0;
        load_full  = 1'b0;
        load_part  = 1'b0;
        shift_en   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    cnt_d      = count;
                    ovl_mode_d = overlap;
                    load_full  = 1'b1;
                    state_d    = (count == '0) ? FIN : SEND;
                end
            end
            SEND: begin
                if (last_bit) begin
                    if (cnt_q > CNT_W'(1)) begin
                        cnt_d     = cnt_q - CNT_W'(1);
                        load_part = ovl_mode_q;
                        load_full = !ovl_mode_q;
                    end else begin
                        state_d = FIN;
                        done_d  = 1'b1;
                    end
                end else begin
                    shift_en = 1'b1;
                end
            end
            FIN: begin
                state_d = IDLE;
                // An empty burst signals completion one cycle after entering FIN.
                done_d  = (cnt_q == '0);
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
        end
    end

    always_ff @(posedge clk) begin
        cnt_q      <= cnt_d;
        ovl_mode_q <= ovl_mode_d;
    end

    assign seq_valid = (state_q == SEND);
    assign busy      = (state_q == SEND);
    assign in_seq    = (state_q == SEND) && msb;
    assign done      = done_q;

`ifdef SEQ_GEN_EXPECT_EN
    logic exp_q;

    always_ff @(posedge clk) begin
        if (rst) exp_q <= 1'b0;
        else     exp_q <= (state_q == SEND) && last_bit;
    end

    assign exp_det = exp_q;
`endif

endmodule

// File: tb/tb_seq_10110_gen.sv
// Randomized bench for seq_10110_gen against a bit-stream reference model.
module tb_seq_10110_gen;

    localparam int         PW  = 5;
    localparam logic [4:0] PAT = 5'b10110;
    localparam int         OVL = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [3:0] count;
    logic       overlap;
    logic       in_seq, seq_valid, busy, done;
`ifdef SEQ_GEN_EXPECT_EN
    logic       exp_det;
`endif

    int n_vec = 0;
    int n_err = 0;

    bit exp_bits[$];
    int ends[$];

    seq_10110_gen dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .count     (count),
        .overlap   (overlap),
        .in_seq    (in_seq),
        .seq_valid (seq_valid),
        .busy      (busy),
        .done      (done)
`ifdef SEQ_GEN_EXPECT_EN
        ,
        .exp_det   (exp_det)
`endif
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Expected serial stream: count instances, later ones dropping their
    // first OVL bits when overlapped; ends[] holds running bit totals.
    function automatic void build(input int c, input bit ov);
        logic [4:0] p;
        int first;
        p = PAT;
        exp_bits.delete();
        ends.delete();
        for (int k = 0; k < c; k++) begin
            first = (ov && k > 0) ? OVL : 0;
            for (int b = first; b < PW; b++) exp_bits.push_back(p[PW-1-b]);
            ends.push_back(exp_bits.size());
        end
    endfunction

    function automatic bit is_end(input int j);
        bit e;
        e = 1'b0;
        foreach (ends[m]) if (ends[m] == j) e = 1'b1;
        return e;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_quiet(input string tag);
        check_eq({tag, "_valid"}, seq_valid, 0);
        check_eq({tag, "_in_seq"}, in_seq, 0);
        check_eq({tag, "_busy"}, busy, 0);
`ifdef SEQ_GEN_EXPECT_EN
        check_eq({tag, "_exp_det"}, exp_det, 0);
`endif
    endtask

    task automatic run_burst(input int c, input bit ov, input int poke_at, input int rst_at);
        int len;
        build(c, ov);
        len     = exp_bits.size();
        start   = 1'b1;
        count   = 4'(c);
        overlap = ov;
        step();
        start   = 1'b0;
        count   = 4'($urandom);
        overlap = 1'($urandom);
        if (c == 0) begin
            check_quiet("zero_e0");
            step();
            check_quiet("zero_e1");
            check_eq("zero_done", done, 1);
            step();
            check_eq("zero_done_off", done, 0);
            return;
        end
        for (int j = 0; j < len; j++) begin
            check_eq("valid", seq_valid, 1);
            check_eq("bit", in_seq, exp_bits[j]);
            check_eq("busy", busy, 1);
            check_eq("done_early", done, 0);
`ifdef SEQ_GEN_EXPECT_EN
            check_eq("exp_det", exp_det, is_end(j));
`endif
            if (j == rst_at) begin
                rst = 1'b1;
                step();
                rst = 1'b0;
                check_quiet("rst_mid");
                check_eq("rst_mid_done", done, 0);
                step();
                check_quiet("rst_after");
                check_eq("rst_after_done", done, 0);
                return;
            end
            start = (j == poke_at);
            count = 4'($urandom);
            step();
            start = 1'b0;
        end
        check_quiet("fin");
        check_eq("fin_done", done, 1);
`ifdef SEQ_GEN_EXPECT_EN
        check_eq("fin_exp_det", exp_det, is_end(len));
`endif
        step();
        check_quiet("post");
        check_eq("post_done", done, 0);
    endtask

    initial begin
        rst     = 1'b1;
        start   = 1'b0;
        count   = '0;
        overlap = 1'b0;
        step();
        step();
        check_quiet("reset");
        check_eq("reset_done", done, 0);
        rst = 1'b0;
        step();

        run_burst(1, 1'b0, -1, -1);
        run_burst(2, 1'b0, -1, -1);
        run_burst(3, 1'b1, -1, -1);
        run_burst(0, 1'b0, -1, -1);
        run_burst(5, 1'b0, 7, -1);
        run_burst(2, 1'b0, -1, 2);
        run_burst(2, 1'b0, -1, -1);
        run_burst(15, 1'b1, 20, -1);

        // Reset and start on the same edge: reset wins.
        rst   = 1'b1;
        start = 1'b1;
        count = 4'd3;
        step();
        rst   = 1'b0;
        start = 1'b0;
        check_quiet("rst_start");
        step();
        check_quiet("rst_start_next");

        repeat (30) begin
            run_burst(int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                      int'($urandom_range(0, 12)), -1);
            repeat ($urandom_range(0, 2)) step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
